// File: rtl/bp_uart.sv
// bp_uart: UART <-> byte-pipe bridge.
// RX deserialises 8N1 frames from i_uart_rx into a one-byte valid/ready
// holding register. TX serialises one accepted byte at a time onto o_uart_tx.
// Neither direction back-pressures the serial line; RX drops bytes on overrun.
module bp_uart #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int RX_SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cg,
    input  logic       i_uart_rx,
    output logic       o_uart_tx,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready,
    output logic       o_rxFrameErr,
    output logic       o_rxOverrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [RX_SYNC_STAGES-1:0] rx_sync_r;
    logic                      rx_s;
    logic                      rx_prev_r;
    rx_state_t                 rx_state_r, rx_state_nxt_s;
    logic [CNT_W-1:0]          rx_cnt_r, rx_cnt_nxt_s;
    logic [2:0]                rx_idx_r, rx_idx_nxt_s;
    logic [7:0]                rx_shift_r, rx_shift_nxt_s;
    logic                      rx_stop_s;
    logic                      rx_load_s;
    logic                      rx_ovr_s;
    logic                      rx_ferr_s;
    logic                      rx_xfer_s;

    // Metastability synchroniser; deliberately not gated so the pin is always tracked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_r <= {RX_SYNC_STAGES{1'b1}};
        end else begin
            rx_sync_r <= {rx_sync_r[RX_SYNC_STAGES-2:0], i_uart_rx};
        end
    end

    assign rx_s = rx_sync_r[RX_SYNC_STAGES-1];

    // RX next-state: edge detect, half-bit start check, full-bit data/stop sampling.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_cnt_nxt_s   = rx_cnt_r;
        rx_idx_nxt_s   = rx_idx_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_stop_s      = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_nxt_s = CNT_ZERO;
                // Only a 1->0 transition starts a frame, so a held break is ignored.
                if (rx_prev_r && !rx_s) begin
                    rx_state_nxt_s = RX_START;
                end else begin
                    rx_state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_nxt_s = CNT_ZERO;
                    rx_idx_nxt_s = 3'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_s) begin
                        rx_state_nxt_s = RX_IDLE;
                    end else begin
                        rx_state_nxt_s = RX_DATA;
                    end
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == CNT_MAX) begin
                    rx_cnt_nxt_s   = CNT_ZERO;
                    rx_shift_nxt_s = {rx_s, rx_shift_r[7:1]};
                    if (rx_idx_r == 3'd7) begin
                        rx_state_nxt_s = RX_STOP;
                    end else begin
                        rx_idx_nxt_s = rx_idx_r + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == CNT_MAX) begin
                    rx_cnt_nxt_s   = CNT_ZERO;
                    rx_state_nxt_s = RX_IDLE;
                    rx_stop_s      = 1'b1;
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_nxt_s = RX_IDLE;
                rx_cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // A consumer draining the holding register this cycle makes room for a new byte.
    assign rx_xfer_s = o_bp_valid & i_bp_ready;
    assign rx_load_s = rx_stop_s & rx_s & (~o_bp_valid | i_bp_ready);
    assign rx_ovr_s  = rx_stop_s & rx_s & o_bp_valid & ~i_bp_ready;
    assign rx_ferr_s = rx_stop_s & ~rx_s;

    // RX state, counters and shift register; frozen while the clock gate is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_prev_r  <= 1'b1;
        end else if (i_cg) begin
            rx_state_r <= rx_state_nxt_s;
            rx_cnt_r   <= rx_cnt_nxt_s;
            rx_idx_r   <= rx_idx_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_prev_r  <= rx_s;
        end
    end

    // RX holding register, handshake and error pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bp_data    <= 8'd0;
            o_bp_valid   <= 1'b0;
            o_rxFrameErr <= 1'b0;
            o_rxOverrun  <= 1'b0;
        end else if (i_cg) begin
            o_rxFrameErr <= rx_ferr_s;
            o_rxOverrun  <= rx_ovr_s;
            if (rx_load_s) begin
                o_bp_data  <= rx_shift_r;
                o_bp_valid <= 1'b1;
            end else if (rx_xfer_s) begin
                o_bp_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t        tx_state_r, tx_state_nxt_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_nxt_s;
    logic [2:0]       tx_idx_r, tx_idx_nxt_s;
    logic [7:0]       tx_shift_r, tx_shift_nxt_s;
    logic             tx_bit_s;

    // TX next-state and next line level; the line is registered from this value.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_cnt_nxt_s   = tx_cnt_r;
        tx_idx_nxt_s   = tx_idx_r;
        tx_shift_nxt_s = tx_shift_r;
        tx_bit_s       = 1'b1;
        case (tx_state_r)
            TX_IDLE: begin
                if (i_bp_valid && o_bp_ready) begin
                    tx_state_nxt_s = TX_START;
                    tx_cnt_nxt_s   = CNT_ZERO;
                    tx_shift_nxt_s = i_bp_data;
                    tx_bit_s       = 1'b0;
                end else begin
                    tx_bit_s = 1'b1;
                end
            end
            TX_START: begin
                tx_bit_s = 1'b0;
                if (tx_cnt_r == CNT_MAX) begin
                    tx_state_nxt_s = TX_DATA;
                    tx_cnt_nxt_s   = CNT_ZERO;
                    tx_idx_nxt_s   = 3'd0;
                    tx_bit_s       = tx_shift_r[0];
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                tx_bit_s = tx_shift_r[0];
                if (tx_cnt_r == CNT_MAX) begin
                    tx_cnt_nxt_s = CNT_ZERO;
                    if (tx_idx_r == 3'd7) begin
                        tx_state_nxt_s = TX_STOP;
                        tx_bit_s       = 1'b1;
                    end else begin
                        tx_idx_nxt_s   = tx_idx_r + 3'd1;
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                        tx_bit_s       = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                tx_bit_s = 1'b1;
                if (tx_cnt_r == CNT_MAX) begin
                    tx_state_nxt_s = TX_IDLE;
                    tx_cnt_nxt_s   = CNT_ZERO;
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_nxt_s = TX_IDLE;
                tx_cnt_nxt_s   = CNT_ZERO;
                tx_bit_s       = 1'b1;
            end
        endcase
    end

    // TX state, counters, line and ready; ready is high exactly while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            o_uart_tx  <= 1'b1;
            o_bp_ready <= 1'b0;
        end else if (i_cg) begin
            tx_state_r <= tx_state_nxt_s;
            tx_cnt_r   <= tx_cnt_nxt_s;
            tx_idx_r   <= tx_idx_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            o_uart_tx  <= tx_bit_s;
            o_bp_ready <= (tx_state_nxt_s == TX_IDLE);
        end
    end

endmodule

// File: tb/tb_bp_uart.sv
// tb_bp_uart: scoreboard bench for bp_uart with CLKS_PER_BIT=4.
// Stimulus pushes expected bytes/frames into queues; independent monitors
// on the falling clock edge pop and compare whatever the DUT presents.
`timescale 1ns/1ps
module tb_bp_uart;

    localparam int C      = 4;
    localparam int SYNC   = 2;
    localparam int RX_LAT = SYNC + C / 2 + 9 * C + 1;
    localparam int FRAME  = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cg = 1'b1;
    logic       uart_rx = 1'b1;
    logic       bp_ready = 1'b1;
    logic       bp_valid_in = 1'b0;
    logic [7:0] bp_data_in = 8'd0;
    logic       uart_tx;
    logic [7:0] bp_data;
    logic       bp_valid;
    logic       bp_ready_out;
    logic       ferr;
    logic       ovr;

    bp_uart #(.CLKS_PER_BIT(C), .RX_SYNC_STAGES(SYNC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cg         (cg),
        .i_uart_rx    (uart_rx),
        .o_uart_tx    (uart_tx),
        .o_bp_data    (bp_data),
        .o_bp_valid   (bp_valid),
        .i_bp_ready   (bp_ready),
        .i_bp_data    (bp_data_in),
        .i_bp_valid   (bp_valid_in),
        .o_bp_ready   (bp_ready_out),
        .o_rxFrameErr (ferr),
        .o_rxOverrun  (ovr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int rise; } rx_exp_t;
    typedef struct { logic [7:0] data; int len;  } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    int got_ferr = 0;
    int got_ovr = 0;
    bit tx_in = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial frame level for frame bit b (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        else if (b >= 9) return 1'b1;
        else return d[b-1];
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive one 8N1 frame; the model decides up front what the DUT must produce.
    task automatic send_rx_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        rx_exp_t    e;
        step();
        if (!stop_bit) begin
            exp_ferr++;
        end else if (rx_q.size() != 0 && !bp_ready) begin
            exp_ovr++;
        end else begin
            e.data = b;
            e.rise = cyc + RX_LAT;
            rx_q.push_back(e);
        end
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (C) step();
        end
    endtask

    // Offer one byte to the TX side once it is ready (bounded wait).
    task automatic send_tx(input logic [7:0] b, input int len);
        tx_exp_t e;
        int      waited = 0;
        step();
        while (!bp_ready_out && waited < 1000) begin
            step();
            waited++;
        end
        check("tx_ready_wait", bp_ready_out, 1);
        if (bp_ready_out) begin
            e.data = b;
            e.len  = len;
            tx_q.push_back(e);
            bp_data_in  = b;
            bp_valid_in = 1'b1;
            step();
            bp_valid_in = 1'b0;
        end
    endtask

    // RX monitor: byte transfers, rise timing and error pulses.
    initial begin : rx_mon
        logic    prev_valid;
        int      rise_cyc;
        rx_exp_t e;
        prev_valid = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bp_valid && !prev_valid) rise_cyc = cyc;
                if (ferr) got_ferr++;
                if (ovr) got_ovr++;
                if (bp_valid && bp_ready && cg) begin
                    check("rx_expected_pending", rx_q.size() != 0, 1);
                    if (rx_q.size() != 0) begin
                        e = rx_q.pop_front();
                        check("rx_data", bp_data, e.data);
                        check("rx_latency", rise_cyc, e.rise);
                    end
                end
                prev_valid = bp_valid;
            end
        end
    end

    // TX monitor: frame waveform in enabled cycles, length and ready behaviour.
    initial begin : tx_mon
        logic    prev_tx;
        logic    last_cg;
        int      eff;
        int      raw;
        int      wave_err;
        int      rdy_err;
        tx_exp_t cur;
        prev_tx = 1'b1;
        last_cg = 1'b1;
        eff = 0; raw = 0; wave_err = 0; rdy_err = 0;
        cur.data = 8'd0; cur.len = FRAME;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_in = 1'b0;
                prev_tx = 1'b1;
            end else if (!tx_in) begin
                if (!uart_tx && prev_tx) begin
                    check("tx_expected_pending", tx_q.size() != 0, 1);
                    if (tx_q.size() != 0) begin
                        cur = tx_q.pop_front();
                    end else begin
                        cur.data = 8'd0;
                        cur.len  = FRAME;
                    end
                    tx_in = 1'b1;
                    eff = 0;
                    raw = 1;
                    wave_err = 0;
                    rdy_err = bp_ready_out ? 1 : 0;
                end
                prev_tx = uart_tx;
            end else begin
                if (last_cg) eff++;
                if (eff == FRAME) begin
                    check("tx_wave", wave_err, 0);
                    check("tx_ready_low", rdy_err, 0);
                    check("tx_frame_len", raw, cur.len);
                    check("tx_ready_back", bp_ready_out, 1);
                    tx_in = 1'b0;
                end else begin
                    raw++;
                    if (uart_tx !== exp_bit(cur.data, eff / C)) wave_err++;
                    if (bp_ready_out) rdy_err++;
                end
                prev_tx = uart_tx;
            end
            last_cg = cg;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_tx", uart_tx, 1);
        check("rst_valid", bp_valid, 0);
        check("rst_data", bp_data, 0);
        check("rst_ready", bp_ready_out, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        check("ready_before_edge", bp_ready_out, 0);
        step();
        check("ready_after_reset", bp_ready_out, 1);

        // Basic RX
        bp_ready = 1'b1;
        send_rx_byte(8'hA5, 1'b1);
        repeat (3 * C) step();
        check("rx_drained_a5", rx_q.size(), 0);

        // Basic TX
        send_tx(8'h3C, FRAME);
        repeat (FRAME + 5) step();
        check("tx_done_3c", tx_in, 0);

        // Overrun and back-pressure
        bp_ready = 1'b0;
        send_rx_byte(8'h11, 1'b1);
        repeat (C) step();
        send_rx_byte(8'h22, 1'b1);
        repeat (3 * C) step();
        check("hold_valid", bp_valid, 1);
        check("hold_data", bp_data, 8'h11);
        check("ovr_count", got_ovr, exp_ovr);
        bp_ready = 1'b1;
        repeat (4) step();
        check("valid_after_drain", bp_valid, 0);
        check("rx_drained_11", rx_q.size(), 0);

        // Frame error followed by a held break
        send_rx_byte(8'h55, 1'b0);
        repeat (30) step();
        uart_rx = 1'b1;
        repeat (3 * C) step();
        check("ferr_count", got_ferr, exp_ferr);
        check("ferr_no_valid", bp_valid, 0);

        // Start glitch
        uart_rx = 1'b0;
        step();
        uart_rx = 1'b1;
        repeat (4 * C) step();
        check("glitch_no_valid", bp_valid, 0);
        check("glitch_no_ferr", got_ferr, exp_ferr);

        // TX with clock gate low for 5 cycles mid-frame
        send_tx(8'hFF, FRAME + 5);
        repeat (15) step();
        cg = 1'b0;
        repeat (5) step();
        cg = 1'b1;
        repeat (FRAME) step();
        check("tx_done_ff", tx_in, 0);

        // Randomised traffic, both directions concurrently
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_rx_byte(8'($urandom_range(0, 255)), 1'b1);
                    uart_rx = 1'b1;
                    repeat ($urandom_range(1, 8)) step();
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    send_tx(8'($urandom_range(0, 255)), FRAME);
                    repeat ($urandom_range(0, 3)) step();
                end
            end
        join
        repeat (FRAME + 3 * C) step();
        check("rx_drained_rand", rx_q.size(), 0);
        check("tx_done_rand", tx_in, 0);

        // Reset in the middle of both directions
        send_tx(8'hC3, FRAME);
        uart_rx = 1'b0;
        repeat (2 * C + 1) step();
        rst_n = 1'b0;
        #1;
        check("midrst_tx", uart_tx, 1);
        check("midrst_valid", bp_valid, 0);
        check("midrst_ready", bp_ready_out, 0);
        uart_rx = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        send_rx_byte(8'h5A, 1'b1);
        repeat (3 * C) step();
        check("rx_drained_5a", rx_q.size(), 0);
        send_tx(8'h5A, FRAME);
        repeat (FRAME + 5) step();
        check("tx_done_5a", tx_in, 0);

        // Totals
        check("ferr_total", got_ferr, exp_ferr);
        check("ovr_total", got_ovr, exp_ovr);
        check("rx_queue_final", rx_q.size(), 0);
        check("tx_queue_final", tx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bp_uart.md
# bp_uart

UART-to-bytepipe bridge that carries host traffic into and out of the byte-pipe register memory. It deserialises 8N1 frames from `i_uart_rx` into a valid/ready byte stream that feeds the register memory's bytepipe input. It also serialises the register memory's bytepipe output onto `o_uart_tx`. There is one byte of buffering per direction, and neither direction applies back-pressure to the serial line.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is 4..255.
- `RX_SYNC_STAGES`, default 2: number of flops in the metastability synchroniser on `i_uart_rx`. Minimum is 2.

- `i_clk`, input, 1: the single clock.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_cg`, input, 1: clock-gate enable. While low, every flop except the RX synchroniser holds.
- `i_uart_rx`, input, 1: serial receive line. Idles high.
- `o_uart_tx`, output, 1: serial transmit line. Idles high.
- `o_bp_data`, output, 8: received byte, toward the register memory's bytepipe input.
- `o_bp_valid`, output, 1: `o_bp_data` holds a byte.
- `i_bp_ready`, input, 1: the downstream stage accepts `o_bp_data`.
- `i_bp_data`, input, 8: byte to transmit, from the register memory's bytepipe output.
- `i_bp_valid`, input, 1: `i_bp_data` is valid.
- `o_bp_ready`, output, 1: the TX side can accept a byte.
- `o_rxFrameErr`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `o_rxOverrun`, output, 1: one-cycle pulse when a received byte is dropped because the holding register is full.

## Operation

**Reset values**
- `o_uart_tx`=1, `o_bp_valid`=0, `o_bp_data`=0, `o_bp_ready`=0.
- `o_rxFrameErr`=0, `o_rxOverrun`=0.
- Synchroniser flops reset to 1. Both FSMs reset to IDLE.

**Frame format**
- 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).

**Counters**
- Bit-period counter width is `$clog2(CLKS_PER_BIT)`, counting 0..CLKS_PER_BIT-1 and wrapping to 0.
- Data-bit index is 3 bits.

**RX FSM**
- IDLE → START on a synchronised falling edge (previous sample 1, current sample 0).
- START: wait `CLKS_PER_BIT/2` cycles (floor), then sample the line.
  - Sample low → DATA.
  - Sample high → IDLE. This is a glitch: no byte, no error.
- DATA: sample every `CLKS_PER_BIT` cycles and shift in at bit index 0..7. After bit 7 → STOP.
- STOP: sample after `CLKS_PER_BIT` cycles, then go to IDLE.
  - Sample 1 and `o_bp_valid`=0: load the byte, set `o_bp_valid`.
  - Sample 1 and `o_bp_valid`=1: keep the old byte, pulse `o_rxOverrun`.
  - Sample 0: discard the byte, pulse `o_rxFrameErr`.
- A line held low (break) after a frame error does not start a new frame. A new frame needs a 1→0 edge.

**RX output handshake**
- The byte transfers on a cycle where `o_bp_valid & i_bp_ready & i_cg`. `o_bp_valid` clears the next cycle.
- While valid and not ready, `o_bp_data` and `o_bp_valid` hold stable.
- If a transfer and a new stop-bit load happen in the same cycle, the new byte is loaded, `o_bp_valid` stays 1, and there is no overrun.

**TX FSM**
- States: IDLE, START, DATA, STOP.
- `o_bp_ready` is registered and equals 1 only in IDLE. It rises 1 cycle after reset deasserts, given `i_cg`=1.
- IDLE + `i_bp_valid` + `o_bp_ready` + `i_cg`: latch `i_bp_data`, go to START, drop `o_bp_ready`.
- START drives 0 for `CLKS_PER_BIT` cycles.
- DATA drives bits 0..7, `CLKS_PER_BIT` cycles each.
- STOP drives 1 for `CLKS_PER_BIT` cycles, then IDLE with `o_bp_ready`=1.

**Clock gating and reset**
- `i_cg`=0 freezes all counters, FSM states, and outputs, including mid-frame. The bit period stretches accordingly.
- `i_rst_n` asserted mid-frame aborts both directions immediately to reset values. No partial byte is ever presented.

## Timing

- **RX latency:** with the falling edge at the synchroniser output in cycle t, `o_bp_valid` rises in cycle t + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1.
- **Synchroniser delay:** `RX_SYNC_STAGES` cycles from pin to synchroniser output.
- **TX frame:** byte accepted at clock edge k. `o_uart_tx` goes low in cycle k+1. The stop bit ends at cycle k + 10·`CLKS_PER_BIT`. `o_bp_ready`=1 in the following cycle.
- **TX throughput:** one byte per 10·`CLKS_PER_BIT` + 1 cycles.
- **Error/overrun pulses:** asserted in the same cycle the byte would have been loaded.
- **Combinational paths:** none from inputs to outputs.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `i_cg`=1 unless stated.

- **Basic RX:** send 0xA5 on `i_uart_rx` with `i_bp_ready`=1 → one `o_bp_valid` pulse with `o_bp_data`=0xA5 at the latency given in Timing; no error pulses.
- **Basic TX:** drive `i_bp_data`=0x3C, `i_bp_valid`=1 for one cycle → `o_uart_tx` shows 0,0,0,1,1,1,1,0,0,1, each held 4 cycles; `o_bp_ready` low for 40 cycles.
- **Overrun and back-pressure:** `i_bp_ready`=0; send 0x11 then 0x22 → `o_bp_data` holds 0x11, one `o_rxOverrun` pulse; raise ready → 0x11 transfers once.
- **Frame error:** send 0x55 with the stop bit low, then hold the line low for 30 cycles → one `o_rxFrameErr` pulse, `o_bp_valid` stays 0, no further frames start.
- **Start glitch and gating:** a 1-cycle low glitch on rx → no byte. A TX of 0xFF with `i_cg` low for 5 cycles mid-frame → the frame is 45 cycles long and its bits are intact.
- **Reset mid-operation:** assert `i_rst_n`=0 mid-RX and mid-TX → `o_uart_tx`=1, `o_bp_valid`=0, `o_bp_ready`=0 immediately; after release, the next 0x5A round-trips correctly.
